input_port_requester: RTL and testbench
=======================================

// Module: input_port_requester
// PURPOSE
//  Requester end of the router output-arbiter handshake: one per router input port.
//  Buffers incoming flits and XY-routes each head flit to one of 5 output ports.
//  Raises that port's one-hot req and holds it until the tail flit has left.
//  Drops req for one cycle so the output arbiter returns to its idle state.
// PARAMETERS
//  DATA_W  16  flit width; [DATA_W-1:DATA_W-2] = type (10 head, 00 body, 01 tail, 11 head+tail)
//  ADDR_W  2   coordinate width; head flit dest_x = [2*ADDR_W-1:ADDR_W], dest_y = [ADDR_W-1:0]
//  DEPTH   4   flit FIFO depth (power of 2, >=2)
//  CUR_X   0   this router's X coordinate
//  CUR_Y   0   this router's Y coordinate
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       asynchronous, active-low reset
//  in_flit   in   DATA_W  flit from upstream link
//  in_valid  in   1       in_flit valid
//  in_ready  out  1       FIFO not full; a flit is accepted when in_valid && in_ready
//  req04..req00  out  1 each  one-hot request to output arbiters: 0 local, 1 E, 2 W, 3 N, 4 S
//  gnt04..gnt00  in   1 each  grants from the same five arbiters
//  out_flit  out  DATA_W  FIFO head flit, to crossbar
//  out_valid out  1       out_flit valid this cycle
//  out_ready in   1       downstream accepts; a flit leaves when out_valid && out_ready
//  drop_err  out  1       one-cycle pulse: a non-head flit was discarded in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, FIFO empty, pointers/count=0, req0x=0, drop_err=0.
//   Resulting outputs: in_ready=1, out_valid=0.
//  FIFO: registered. A push at edge t makes the flit visible at the head after t.
//   Push while full is impossible (in_ready=0).
//   Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
//  Route (XY), from the head flit:
//   dest_x>CUR_X -> E(1); dest_x<CUR_X -> W(2);
//   else dest_y>CUR_Y -> N(3); dest_y<CUR_Y -> S(4); else local(0). Unsigned compares.
//  FSM states: IDLE, WAIT_GNT, SEND, RELEASE.
//  - IDLE, FIFO empty: stay.
//  - IDLE, head type=head or head+tail: latch sel; register req[sel]=1 -> WAIT_GNT.
//  - IDLE, head type=body or tail: pop it, drop_err=1 for one cycle, stay IDLE.
//  - WAIT_GNT: hold req[sel]. gnt[sel]=1 -> SEND. Grants on other indices are ignored.
//  - SEND: out_valid = !empty && gnt[sel] (combinational); out_flit = FIFO head.
//   A pop of type tail or head+tail -> RELEASE, with req cleared at the same edge.
//   If gnt[sel] falls mid-packet: out_valid=0, req stays high, stay in SEND.
//  - RELEASE: all req=0 for exactly one cycle -> IDLE.
//   This guarantees the arbiter sees req low and re-arbitrates.
//  Latency on an uncontended port:
//   push edge 0 -> req high after edge 1 -> gnt after edge 2
//   -> head flit out_valid in cycle 3 -> next packet's req no earlier than 2 cycles after the tail pops.
//  At most one req bit is high at any time. req is never dropped between head and tail.
//  Reset mid-packet aborts it: FIFO flushed, req cleared immediately (async).
//  Single-flit packet (type 11): goes IDLE -> WAIT_GNT -> SEND (1 pop) -> RELEASE.
// TESTING
//  1 Reset: rst=0 with in_valid=1 -> req0x=0, out_valid=0, in_ready=1; no push while reset is asserted.
//  2 CUR=(1,1), 3-flit packet to (2,1), gnt01 follows req01 by 1 cycle
//    -> req01 only, 3 flits out in order, req01 low 1 cycle after the tail pops.
//  3 Dest (1,1) head+tail at CUR=(1,1) -> req00, 1 flit out, RELEASE cycle, back in IDLE.
//  4 Body flit 0x0005 first in FIFO -> drop_err pulse, no req, next head routed normally.
//  5 gnt held low 10 cycles; DEPTH+1 pushes -> in_ready=0 after 4 pushes, req held, no out_valid.
//    Then grant -> all 4 flits drain.
//  6 gnt04 dropped 2 cycles mid-packet -> out_valid=0 for those cycles, req04 stays high, no flit lost.

Source files
------------

// File: rtl/input_port_requester_if.sv
// Handshake bundle between one router input port and the rest of the router:
// upstream flit link, one-hot req/gnt pairs to the five output arbiters,
// and the downstream flit path toward the crossbar.
interface input_port_requester_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic              req00, req01, req02, req03, req04;
  logic              gnt00, gnt01, gnt02, gnt03, gnt04;
  logic [DATA_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic              drop_err;

  // Requester view: the input port itself.
  modport master (
    input  in_flit, in_valid, out_ready,
    input  gnt00, gnt01, gnt02, gnt03, gnt04,
    output in_ready, out_flit, out_valid, drop_err,
    output req00, req01, req02, req03, req04
  );

  // Router view: upstream link, arbiters and crossbar.
  modport slave (
    output in_flit, in_valid, out_ready,
    output gnt00, gnt01, gnt02, gnt03, gnt04,
    input  in_ready, out_flit, out_valid, drop_err,
    input  req00, req01, req02, req03, req04
  );
endinterface

// File: rtl/input_port_requester.sv
// Router input port requester: buffers flits in a small FIFO, XY-routes each
// head flit, holds a one-hot request to the chosen output arbiter until the
// tail has left, then drops all requests for one cycle so the arbiter
// re-arbitrates. Non-head flits found at the FIFO head while idle are dropped.
module input_port_requester #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input_port_requester_if.master      bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] CUR_X_C = ADDR_W'(CUR_X);
  localparam logic [ADDR_W-1:0] CUR_Y_C = ADDR_W'(CUR_Y);
  localparam logic [PTR_W:0]    FULL_C  = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, SEND, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        req_q, req_d;
  logic              drop_err_q, drop_err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] head_flit;
  logic [1:0]        head_type;
  logic [4:0]        gnt_vec;
  logic              gnt_sel;
  logic              empty;
  logic              in_ready;
  logic              push;
  logic              pop;
  logic              out_valid;

  // XY routing: resolve X first, then Y; returns the one-hot output port.
  function automatic logic [4:0] route(input logic [DATA_W-1:0] flit);
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;
    dx = flit[2*ADDR_W-1:ADDR_W];
    dy = flit[ADDR_W-1:0];
    if (dx > CUR_X_C)      route = 5'b00010;
    else if (dx < CUR_X_C) route = 5'b00100;
    else if (dy > CUR_Y_C) route = 5'b01000;
    else if (dy < CUR_Y_C) route = 5'b10000;
    else                   route = 5'b00001;
  endfunction

  assign head_flit = mem_q[rd_ptr_q];
  assign head_type = head_flit[DATA_W-1:DATA_W-2];
  assign gnt_vec   = {bus.gnt04, bus.gnt03, bus.gnt02, bus.gnt01, bus.gnt00};
  // req_q is one-hot on the selected port in WAIT_GNT/SEND, so it doubles as the select mask.
  assign gnt_sel   = |(gnt_vec & req_q);
  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != FULL_C);
  assign push      = bus.in_valid && in_ready;

  // Packet FSM: next state, request register, drop pulse, output valid and pop.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    drop_err_d = 1'b0;
    out_valid  = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_type[1]) begin
            req_d   = route(head_flit);
            state_d = WAIT_GNT;
          end else begin
            pop        = 1'b1;
            drop_err_d = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        if (gnt_sel) state_d = SEND;
      end
      SEND: begin
        out_valid = !empty && gnt_sel;
        pop       = out_valid && bus.out_ready;
        if (pop && head_type[0]) begin
          req_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  // Control state; reset aborts any packet in flight and flushes the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      drop_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      drop_err_q <= drop_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Flit storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_flit;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = head_flit;
  assign bus.drop_err  = drop_err_q;
  assign bus.req00     = req_q[0];
  assign bus.req01     = req_q[1];
  assign bus.req02     = req_q[2];
  assign bus.req03     = req_q[3];
  assign bus.req04     = req_q[4];

endmodule

// File: tb/tb_input_port_requester.sv
// Directed bench for input_port_requester at router (1,1): table of per-cycle
// input/expected-output records plus hand-written reset sequences.
module tb_input_port_requester;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  input_port_requester_if #(.DATA_W(16)) bus ();

  input_port_requester #(
    .DATA_W(16), .ADDR_W(2), .DEPTH(4), .CUR_X(1), .CUR_Y(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] fl;
    logic        ordy;
    logic [4:0]  gnt;
    logic [4:0]  req;
    logic        ov;
    logic [15:0] oflit;
    logic        ir;
    logic        de;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input logic [15:0] fl, input logic ordy,
                     input logic [4:0] gnt, input logic [4:0] req, input logic ov,
                     input logic [15:0] oflit, input logic ir, input logic de);
    vec_t v;
    v.iv = iv; v.fl = fl; v.ordy = ordy; v.gnt = gnt;
    v.req = req; v.ov = ov; v.oflit = oflit; v.ir = ir; v.de = de;
    vq.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [15:0] fl, input logic ordy,
                       input logic [4:0] gnt);
    bus.in_valid  = iv;
    bus.in_flit   = fl;
    bus.out_ready = ordy;
    {bus.gnt04, bus.gnt03, bus.gnt02, bus.gnt01, bus.gnt00} = gnt;
  endtask

  task automatic check(input string name, input logic [4:0] req_e, input logic ov_e,
                       input logic [15:0] of_e, input logic ir_e, input logic de_e);
    logic [4:0] req_a;
    req_a = {bus.req04, bus.req03, bus.req02, bus.req01, bus.req00};
    n_vec++;
    if (req_a !== req_e || bus.out_valid !== ov_e || (ov_e && bus.out_flit !== of_e) ||
        bus.in_ready !== ir_e || bus.drop_err !== de_e) begin
      n_err++;
      $display("FAIL %s: got req=%b ov=%b flit=%h ir=%b de=%b, want req=%b ov=%b flit=%h ir=%b de=%b",
               name, req_a, bus.out_valid, bus.out_flit, bus.in_ready, bus.drop_err,
               req_e, ov_e, of_e, ir_e, de_e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // 3-flit packet to (2,1): east; a stray west grant is ignored while waiting.
    add(1, 16'h8009, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'h0123, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'h4456, 0, 5'b00100, 5'b00010, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00010, 5'b00010, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00010, 5'b00010, 1, 16'h8009, 1, 0);
    add(0, 16'h0000, 1, 5'b00010, 5'b00010, 1, 16'h0123, 1, 0);
    add(0, 16'h0000, 1, 5'b00010, 5'b00010, 1, 16'h4456, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    // Head+tail to (1,1): local port.
    add(1, 16'hC005, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00001, 5'b00001, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00001, 5'b00001, 1, 16'hC005, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    // Stray body flit dropped, then head+tail to (0,1): west.
    add(1, 16'h0005, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'hC001, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 1);
    add(0, 16'h0000, 1, 5'b00100, 5'b00100, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00100, 5'b00100, 1, 16'hC001, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    // Grant withheld 10 cycles, five pushes attempted into a 4-deep FIFO: south.
    add(1, 16'h8004, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'h0011, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'h0022, 0, 5'b00000, 5'b10000, 0, 16'h0000, 1, 0);
    add(1, 16'h4033, 0, 5'b00000, 5'b10000, 0, 16'h0000, 1, 0);
    for (int k = 0; k < 6; k++)
      add(1, 16'h8005, 0, 5'b00000, 5'b10000, 0, 16'h0000, 0, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 0, 16'h0000, 0, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h8004, 0, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h0011, 1, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h0022, 1, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h4033, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    // South packet with the grant dropped for two cycles mid-packet.
    add(1, 16'h8104, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'h0A0A, 0, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(1, 16'h4B0B, 0, 5'b00000, 5'b10000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h8104, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b10000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b10000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h0A0A, 1, 0);
    add(0, 16'h0000, 1, 5'b10000, 5'b10000, 1, 16'h4B0B, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);
    add(0, 16'h0000, 1, 5'b00000, 5'b00000, 0, 16'h0000, 1, 0);

    // Reset held with a valid flit on the link: nothing may be accepted.
    rst = 1'b0;
    drive(1, 16'h8009, 0, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", k), 5'b00000, 0, 16'h0000, 1, 0);
      @(posedge clk);
    end
    #1;
    rst = 1'b1;

    // Table: inputs driven just after the rising edge, outputs sampled on the falling edge.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].iv, vq[i].fl, vq[i].ordy, vq[i].gnt);
      @(negedge clk);
      check($sformatf("vec%0d", i), vq[i].req, vq[i].ov, vq[i].oflit, vq[i].ir, vq[i].de);
      @(posedge clk);
      #1;
    end

    // Reset mid-packet: request clears without a clock edge, FIFO is flushed.
    drive(1, 16'h8009, 0, 5'b00000);
    @(posedge clk); #1;
    drive(1, 16'h0123, 0, 5'b00000);
    @(posedge clk); #1;
    drive(0, 16'h0000, 1, 5'b00000);
    @(negedge clk);
    check("midpkt_req", 5'b00010, 0, 16'h0000, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", 5'b00000, 0, 16'h0000, 1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("flushed%0d", k), 5'b00000, 0, 16'h0000, 1, 0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
